// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle control FSM: FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK,
//   one stage per cycle. It stalls on the instruction/data memory ready
//   handshakes, and a wait that runs too long halts the machine with a bus error.
//
// Ports
//   clk, reset (async, active-low)
//   opcode          instruction opcode, latched while irWrite=1
//   isAluOutputZero ALU zero flag, consumed in EXECUTE
//   imemReady       instruction memory data valid
//   dmemReady       data memory access complete
//   pcWrite, irWrite, memRead, memWrite, regWrite,
//   regDst, aluSrc, memToReg, jump, branchC, aluOp   datapath controls
//   state           current state code
//   retired         instructions completed (wraps)
//   illegalOp       sticky flag: unknown opcode decoded
//   busError        sticky flag: memory ready timeout
module multicycle_controller #(
  parameter int OPCODE_WIDTH = 6,
  parameter int ALUOP_WIDTH  = 4,
  parameter int CNT_WIDTH    = 32,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    isAluOutputZero,
  input  logic                    imemReady,
  input  logic                    dmemReady,
  output logic                    pcWrite,
  output logic                    irWrite,
  output logic                    memRead,
  output logic                    memWrite,
  output logic                    regWrite,
  output logic                    regDst,
  output logic                    aluSrc,
  output logic                    memToReg,
  output logic                    jump,
  output logic [1:0]              branchC,
  output logic [ALUOP_WIDTH-1:0]  aluOp,
  output logic [2:0]              state,
  output logic [CNT_WIDTH-1:0]    retired,
  output logic                    illegalOp,
  output logic                    busError
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_R    = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_J    = OPCODE_WIDTH'(6'b000010);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(6'b000101);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(6'b001000);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = OPCODE_WIDTH'(6'b111111);

  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = ALUOP_WIDTH'(4'b0010);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB  = ALUOP_WIDTH'(4'b0110);
  localparam logic [ALUOP_WIDTH-1:0] ALU_FUNC = ALUOP_WIDTH'(4'b1111);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t                  st, st_n;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    wait_inc;
  logic                    retire;
  logic                    set_ill;
  logic                    set_bus;

  assign state = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= S_FETCH;
      op_q      <= '0;
      wait_cnt  <= '0;
      retired   <= '0;
      illegalOp <= 1'b0;
      busError  <= 1'b0;
    end else begin
      st <= st_n;
      if (irWrite) op_q <= opcode;
      // Any cycle that is not a counted stall (ready, state change) clears it.
      wait_cnt <= wait_inc ? wait_cnt + 1'b1 : '0;
      if (retire)  retired   <= retired + CNT_WIDTH'(1);
      if (set_ill) illegalOp <= 1'b1;
      if (set_bus) busError  <= 1'b1;
    end
  end

  always_comb begin
    st_n     = st;
    wait_inc = 1'b0;
    retire   = 1'b0;
    set_ill  = 1'b0;
    set_bus  = 1'b0;
    pcWrite  = 1'b0;
    irWrite  = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    regWrite = 1'b0;
    regDst   = 1'b0;
    aluSrc   = 1'b0;
    memToReg = 1'b0;
    jump     = 1'b0;
    branchC  = 2'b00;
    aluOp    = '0;
    // Controls are held inactive for as long as reset is low, not just
    // until the registers settle.
    if (reset) begin
      case (st)
        S_FETCH: begin
          memRead = 1'b1;
          if (imemReady) begin
            irWrite = 1'b1;
            pcWrite = 1'b1;
            st_n    = S_DECODE;
          end else if (wait_cnt == WAIT_MAX) begin
            set_bus = 1'b1;
            st_n    = S_HALTED;
          end else begin
            wait_inc = 1'b1;
          end
        end
        S_DECODE: begin
          case (op_q)
            OP_J: begin
              jump    = 1'b1;
              pcWrite = 1'b1;
              retire  = 1'b1;
              st_n    = S_FETCH;
            end
            OP_HALT: begin
              retire = 1'b1;
              st_n   = S_HALTED;
            end
            OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: st_n = S_EXECUTE;
            default: begin
              set_ill = 1'b1;
              st_n    = S_FETCH;
            end
          endcase
        end
        S_EXECUTE: begin
          st_n = S_FETCH;
          case (op_q)
            OP_R: begin
              regDst = 1'b1;
              aluOp  = ALU_FUNC;
              st_n   = S_WRITEBACK;
            end
            OP_ADDI: begin
              aluSrc = 1'b1;
              aluOp  = ALU_ADD;
              st_n   = S_WRITEBACK;
            end
            OP_LW, OP_SW: begin
              aluSrc = 1'b1;
              aluOp  = ALU_ADD;
              st_n   = S_MEMORY;
            end
            OP_BEQ: begin
              aluOp   = ALU_SUB;
              branchC = 2'b01;
              pcWrite = isAluOutputZero;
              retire  = 1'b1;
            end
            OP_BNE: begin
              aluOp   = ALU_SUB;
              branchC = 2'b10;
              pcWrite = !isAluOutputZero;
              retire  = 1'b1;
            end
            default: st_n = S_FETCH;
          endcase
        end
        S_MEMORY: begin
          memRead  = (op_q == OP_LW);
          memWrite = (op_q != OP_LW);
          if (dmemReady) begin
            if (op_q == OP_LW) begin
              st_n = S_WRITEBACK;
            end else begin
              retire = 1'b1;
              st_n   = S_FETCH;
            end
          end else if (wait_cnt == WAIT_MAX) begin
            set_bus = 1'b1;
            st_n    = S_HALTED;
          end else begin
            wait_inc = 1'b1;
          end
        end
        S_WRITEBACK: begin
          regWrite = 1'b1;
          memToReg = (op_q == OP_LW);
          retire   = 1'b1;
          st_n     = S_FETCH;
        end
        S_HALTED: st_n = S_HALTED;
        default:  st_n = S_FETCH;
      endcase
    end
  end

endmodule
